// File: rtl/estagio_ula_n.sv
// rtl/estagio_ula_n.sv - clocked dual-rail ALU pipeline stage with four-phase DATA/NULL handshake
// Optional feature macro: ESTAGIO_ULA_N_ILLEGAL_DET_EN (illegal 11 codeword detection, sticky err)
module estagio_ula_n #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ack_in,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic [3:0]     opr,
  output logic           ack_out,
  output logic [2*W-1:0] soma,
  output logic [1:0]     of,
  output logic [1:0]     zero,
  output logic [1:0]     neg,
  output logic [1:0]     cout,
  output logic           err
);

  localparam int NP = 2 * W + 2;

  typedef enum logic {S_NULL = 1'b0, S_DATA = 1'b1} state_t;

  state_t state_q, state_d;

  // Captured result, single-rail: {r, of, zero, neg, carry}
  logic [W+3:0] res_q, res_d;
  logic         err_q, err_d;

  logic [2*NP-1:0] pairs;
  logic            all_data, all_null, any_illegal;

  logic [W-1:0] a_x, b_x, r;
  logic [W:0]   sum;
  logic [1:0]   op;
  logic         ovf, carry;

  assign pairs = {opr, b, a};

  // Completion detection over every input pair
  always_comb begin
    all_data    = 1'b1;
    all_null    = 1'b1;
    any_illegal = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (pairs[2*i +: 2] == 2'b11) any_illegal = 1'b1;
      if (pairs[2*i +: 2] != 2'b00) all_null = 1'b0;
`ifdef ESTAGIO_ULA_N_ILLEGAL_DET_EN
      if (!(^pairs[2*i +: 2])) all_data = 1'b0;
`else
      // An 11 pair counts as a valid logic 1
      if (pairs[2*i +: 2] == 2'b00) all_data = 1'b0;
`endif
    end
`ifdef ESTAGIO_ULA_N_ILLEGAL_DET_EN
    if (any_illegal) begin
      all_data = 1'b0;
      all_null = 1'b0;
    end
`endif
  end

  // Single-rail decode (rail1) and ALU evaluation
  always_comb begin
    for (int i = 0; i < W; i++) begin
      a_x[i] = a[2*i+1];
      b_x[i] = b[2*i+1];
    end
    op    = {opr[3], opr[1]};
    sum   = '0;
    r     = '0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (op)
      2'b00: begin
        sum   = {1'b0, a_x} + {1'b0, b_x};
        r     = sum[W-1:0];
        carry = sum[W];
        ovf   = (a_x[W-1] == b_x[W-1]) && (r[W-1] != a_x[W-1]);
      end
      2'b01: begin
        // carry here means "no borrow"
        sum   = {1'b0, a_x} + {1'b0, ~b_x} + {{W{1'b0}}, 1'b1};
        r     = sum[W-1:0];
        carry = sum[W];
        ovf   = (a_x[W-1] != b_x[W-1]) && (r[W-1] != a_x[W-1]);
      end
      2'b10: r = a_x & b_x;
      default: r = a_x ^ b_x;
    endcase
    res_d = {r, ovf, (r == '0), r[W-1], carry};
  end

  // Sticky illegal-codeword flag
  always_comb begin
`ifdef ESTAGIO_ULA_N_ILLEGAL_DET_EN
    err_d = err_q | any_illegal;
`else
    err_d = 1'b0;
`endif
  end

  // State, result and error registers; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NULL;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == S_NULL && state_d == S_DATA) res_q <= res_d;
    end
  end

  // Next state: synchronous C-element, holds on anything but a full wavefront with matching ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NULL:  if (all_data && !ack_in) state_d = S_DATA;
      default: if (all_null && ack_in)  state_d = S_NULL;
    endcase
  end

  // Outputs: dual-rail encode of the captured result in S_DATA, all NULL otherwise
  always_comb begin
    ack_out = 1'b0;
    soma    = '0;
    of      = 2'b00;
    zero    = 2'b00;
    neg     = 2'b00;
    cout    = 2'b00;
    if (state_q == S_DATA) begin
      ack_out = 1'b1;
      for (int i = 0; i < W; i++) begin
        soma[2*i+1] = res_q[i+4];
        soma[2*i]   = ~res_q[i+4];
      end
      of   = {res_q[3], ~res_q[3]};
      zero = {res_q[2], ~res_q[2]};
      neg  = {res_q[1], ~res_q[1]};
      cout = {res_q[0], ~res_q[0]};
    end
    err = err_q;
  end

endmodule

// File: tb/tb_estagio_ula_n.sv
// tb/tb_estagio_ula_n.sv - self-checking bench for estagio_ula_n with an arithmetic reference model
module tb_estagio_ula_n;

  localparam int W  = 8;
  localparam int OW = 2 * W + 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           ack_in;
  logic [2*W-1:0] a, b;
  logic [3:0]     opr;
  logic           ack_out;
  logic [2*W-1:0] soma;
  logic [1:0]     of, zero, neg, cout;
  logic           err;

  logic [OW-1:0]  obs;
  logic [OW-1:0]  expv;
  int errors = 0;
  int checks = 0;

  estagio_ula_n #(.W(W)) dut (
    .clk(clk), .rst(rst), .ack_in(ack_in), .a(a), .b(b), .opr(opr),
    .ack_out(ack_out), .soma(soma), .of(of), .zero(zero), .neg(neg),
    .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  assign obs = {ack_out, soma, of, zero, neg, cout, err};

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] o;
    for (int i = 0; i < W; i++) o[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return o;
  endfunction

  function automatic logic [1:0] enc1(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  // Reference: plain integer arithmetic, signed range checks for overflow
  function automatic logic [OW-1:0] model(input logic [1:0] op, input logic [W-1:0] av,
                                          input logic [W-1:0] bv, input logic e);
    int ua, ub, sa, sb, full, sfull;
    logic [W-1:0] r;
    logic c, o;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    c = 1'b0;
    o = 1'b0;
    case (op)
      2'd0: begin
        full  = ua + ub;
        sfull = sa + sb;
        r = full[W-1:0];
        c = (full >= 2**W);
        o = (sfull > 2**(W-1) - 1) || (sfull < -(2**(W-1)));
      end
      2'd1: begin
        full  = ua - ub;
        sfull = sa - sb;
        r = full[W-1:0];
        c = (ua >= ub);
        o = (sfull > 2**(W-1) - 1) || (sfull < -(2**(W-1)));
      end
      2'd2: r = av & bv;
      default: r = av ^ bv;
    endcase
    return {1'b1, enc(r), enc1(o), enc1(r == '0), enc1(r[W-1]), enc1(c), e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data(input logic [1:0] op, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic ack);
    a      = enc(av);
    b      = enc(bv);
    opr    = {enc1(op[1]), enc1(op[0])};
    ack_in = ack;
  endtask

  task automatic drive_null(input logic ack);
    a      = '0;
    b      = '0;
    opr    = '0;
    ack_in = ack;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_null(1'b0);
    tick();
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, {OW{1'b0}});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    // 0x7F + 0x01: signed overflow
    drive_data(2'd0, 8'h7F, 8'h01, 1'b0);
    tick();
    expv = {1'b1, enc(8'h80), 2'b10, 2'b01, 2'b10, 2'b01, 1'b0};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL add_7f_01: got %h want %h", obs, expv);
    end
    // NULL with ack_in still 0: hold
    drive_null(1'b0);
    tick();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL null_ack_mismatch_hold: got %h want %h", obs, expv);
    end
    drive_null(1'b1);
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL return_to_null: got %h want 0", obs);
    end
    // 5 - 5
    drive_data(2'd1, 8'h05, 8'h05, 1'b0);
    tick();
    expv = {1'b1, enc(8'h00), 2'b01, 2'b10, 2'b01, 2'b10, 1'b0};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL sub_05_05: got %h want %h", obs, expv);
    end
    drive_null(1'b1);
    tick();
    // 0xFF + 0x01: wrap with carry
    drive_data(2'd0, 8'hFF, 8'h01, 1'b0);
    tick();
    expv = {1'b1, enc(8'h00), 2'b01, 2'b10, 2'b01, 2'b10, 1'b0};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL add_ff_01: got %h want %h", obs, expv);
    end
    drive_null(1'b1);
    tick();
    // 0xF0 ^ 0xFF
    drive_data(2'd3, 8'hF0, 8'hFF, 1'b0);
    tick();
    expv = {1'b1, enc(8'h0F), 2'b01, 2'b01, 2'b01, 2'b01, 1'b0};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL xor_f0_ff: got %h want %h", obs, expv);
    end
    drive_null(1'b1);
    tick();
  endtask

  task automatic test_handshake();
    // Partial wavefront in NULL: no capture
    drive_null(1'b0);
    a = enc(8'h12);
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL partial_wavefront_hold: got %h want 0", obs);
    end
    // Complete DATA but ack_in=1 for three edges
    drive_data(2'd2, 8'h3C, 8'h0F, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL data_with_ack_hold cyc%0d: got %h want 0", k, obs);
      end
    end
    ack_in = 1'b0;
    tick();
    expv = model(2'd2, 8'h3C, 8'h0F, 1'b0);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL capture_after_ack_drop: got %h want %h", obs, expv);
    end
    // Mixed NULL/DATA in S_DATA with ack_in=1: hold
    b      = '0;
    ack_in = 1'b1;
    tick();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL mixed_in_data_hold: got %h want %h", obs, expv);
    end
    drive_null(1'b1);
    tick();
  endtask

  task automatic test_reset_mid_data();
    drive_data(2'd1, 8'h10, 8'h20, 1'b0);
    tick();
    expv = model(2'd1, 8'h10, 8'h20, 1'b0);
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_mid_data: got %h want 0", obs);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL recapture_after_reset: got %h want %h", obs, expv);
    end
    drive_null(1'b1);
    tick();
  endtask

  task automatic test_illegal();
    drive_data(2'd0, 8'h40, 8'h02, 1'b0);
    a[1:0] = 2'b11;
    tick();
`ifdef ESTAGIO_ULA_N_ILLEGAL_DET_EN
    expv = {{(OW-1){1'b0}}, 1'b1};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL illegal_sets_err: got %h want %h", obs, expv);
    end
    drive_data(2'd0, 8'h40, 8'h02, 1'b0);
    tick();
    expv = model(2'd0, 8'h40, 8'h02, 1'b1);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL err_sticky_valid: got %h want %h", obs, expv);
    end
    rst = 1'b1;
    drive_null(1'b0);
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL err_cleared_by_rst: got %h want 0", obs);
    end
`else
    expv = model(2'd0, 8'h41, 8'h02, 1'b0);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL illegal_as_one: got %h want %h", obs, expv);
    end
    drive_null(1'b1);
    tick();
`endif
  endtask

  task automatic test_random();
    logic [1:0]   op, op2;
    logic [W-1:0] av, bv, av2, bv2;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      av = W'($urandom);
      bv = W'($urandom);
      if (n < 4) begin
        av = (n[0]) ? 8'h80 : 8'h7F;
        bv = (n[1]) ? 8'h80 : 8'hFF;
      end
      drive_data(op, av, bv, 1'b0);
      tick();
      expv = model(op, av, bv, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL rand_capture #%0d op=%0d a=%h b=%h: got %h want %h", n, op, av, bv, obs, expv);
      end
      // A new wavefront while still in S_DATA must not be captured
      op2 = 2'($urandom_range(0, 3));
      av2 = W'($urandom);
      bv2 = W'($urandom);
      drive_data(op2, av2, bv2, 1'b0);
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL rand_hold #%0d: got %h want %h", n, obs, expv);
      end
      drive_null(1'b1);
      tick();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL rand_null #%0d: got %h want 0", n, obs);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_null(1'b0);
    test_reset();
    test_directed();
    test_handshake();
    test_reset_mid_data();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
